mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and parameter defaults for the data-memory pipeline stage.
package mem_stage_pkg;

    localparam int ARQ_DEFAULT              = 16;
    localparam int MEMORY_ADDR_SIZE_DEFAULT = 13;
    localparam int ACK_TIMEOUT_DEFAULT      = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Control half of the EXE/MEM bundle; operand fields are sized by each instance's ARQ.
    typedef struct packed {
        logic wb_enable;
        logic rd_mem;
        logic wr_mem;
        logic pc;
    } exe_mem_ctrl_t;

    function automatic logic is_mem_op(input exe_mem_ctrl_t c);
        return c.rd_mem | c.wr_mem;
    endfunction

    // A simultaneous read+write is treated as a write.
    function automatic logic is_read(input exe_mem_ctrl_t c);
        return c.rd_mem & ~c.wr_mem;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles without an acknowledge and flags when the limit is reached.
module mem_wait_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic timeout
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance && !timeout) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (count == CW'(ACK_TIMEOUT));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU pass-through or a single blocking data-memory access with timeout.
//
// state  | meaning
// IDLE   | accepting EXE operands; ALU results retire one cycle later
// ACCESS | request held on the memory port until ack or timeout
// RESP   | one-cycle retirement of the memory result, then back to IDLE
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ARQ              = ARQ_DEFAULT,
    parameter int MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEFAULT,
    parameter int ACK_TIMEOUT      = ACK_TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exe_valid,
    input  logic [ARQ-1:0]              alu_result_mem_in,
    input  logic [ARQ-1:0]              src3_mem_in,
    input  logic [ARQ-1:0]              src1_mem_in,
    input  logic                        wb_enable_mem_in,
    input  logic                        rd_mem_mem_in,
    input  logic                        wr_mem_mem_in,
    input  logic                        pc_mem_in,
    output logic                        mem_busy,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic [ARQ-1:0]              mem_rdata,
    input  logic                        mem_ack,
    output logic                        wb_valid,
    output logic                        wb_enable_out,
    output logic                        wb_pc_out,
    output logic [ARQ-1:0]              wb_result_out,
    output logic [ARQ-1:0]              wb_tag_out,
    output logic                        mem_error
);

    state_t        state, state_nxt;
    exe_mem_ctrl_t ctrl_in, ctrl_q;
    logic [ARQ-1:0] alu_q, wdata_q, tag_q;
    logic          start, pass, ack_seen, timed_out, timeout;

    assign ctrl_in = '{wb_enable: wb_enable_mem_in, rd_mem: rd_mem_mem_in,
                       wr_mem: wr_mem_mem_in, pc: pc_mem_in};

    assign start     = (state == IDLE) && exe_valid && is_mem_op(ctrl_in);
    assign pass      = (state == IDLE) && exe_valid && !is_mem_op(ctrl_in);
    assign ack_seen  = (state == ACCESS) && mem_ack;
    assign timed_out = (state == ACCESS) && !mem_ack && timeout;

    mem_wait_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .advance ((state == ACCESS) && !mem_ack),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_busy  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                mem_busy = start;
                if (start) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_busy = 1'b1;
                mem_req  = 1'b1;
                mem_we   = ctrl_q.wr_mem;
                if (ack_seen || timed_out) state_nxt = RESP;
            end
            RESP: begin
                mem_busy  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr  = alu_q[MEMORY_ADDR_SIZE-1:0];
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q        <= '0;
            alu_q         <= '0;
            wdata_q       <= '0;
            tag_q         <= '0;
            wb_valid      <= 1'b0;
            wb_enable_out <= 1'b0;
            wb_pc_out     <= 1'b0;
            wb_result_out <= '0;
            wb_tag_out    <= '0;
            mem_error     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (pass) begin
                wb_valid      <= 1'b1;
                wb_result_out <= alu_result_mem_in;
                wb_tag_out    <= src1_mem_in;
                wb_enable_out <= wb_enable_mem_in;
                wb_pc_out     <= pc_mem_in;
            end
            if (start) begin
                ctrl_q  <= ctrl_in;
                alu_q   <= alu_result_mem_in;
                wdata_q <= src3_mem_in;
                tag_q   <= src1_mem_in;
            end
            if (ack_seen) begin
                wb_valid      <= 1'b1;
                wb_result_out <= is_read(ctrl_q) ? mem_rdata : alu_q;
                wb_enable_out <= ctrl_q.wb_enable & ~ctrl_q.wr_mem;
                wb_tag_out    <= tag_q;
                wb_pc_out     <= ctrl_q.pc;
            end else if (timed_out) begin
                wb_valid      <= 1'b1;
                wb_result_out <= '0;
                wb_enable_out <= 1'b0;
                wb_tag_out    <= tag_q;
                wb_pc_out     <= ctrl_q.pc;
                mem_error     <= 1'b1;
            end
        end
    end

endmodule
